// File: rtl/smp_pkg.sv
// smp_pkg: shared coherence types for the snoop responder.
// Line/address widths and MSI encodings used by snoop_resp and snoop_wb.
package smp_pkg;

  localparam int LINE_W  = 64;
  localparam int BOCI_W  = 13;
  localparam int DMEM_AW = 11;

  typedef enum logic [1:0] {
    INVALID  = 2'b00,
    SHARED   = 2'b01,
    MODIFIED = 2'b10
  } block_state_t;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    RESP,
    WB,
    UPDATE
  } snoop_state_t;

  // 2'b11 is not a legal MSI state and reads as a miss
  function automatic logic is_valid(input logic [1:0] s);
    return (s == SHARED) || (s == MODIFIED);
  endfunction

endpackage

// File: rtl/snoop_wb.sv
// snoop_wb: holds a MODIFIED line for d_mem writeback.
// Request stays asserted with stable addr/data until u_rdy.
module snoop_wb
  import smp_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [DMEM_AW-1:0] addr,
  input  logic [LINE_W-1:0]  line,
  input  logic               u_rdy,
  output logic               wb_we,
  output logic [DMEM_AW-1:0] wb_addr,
  output logic [LINE_W-1:0]  wb_line
);

  logic               we_q;
  logic [DMEM_AW-1:0] addr_q;
  logic [LINE_W-1:0]  line_q;

  // capture line on start, drop request on the acknowledged cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q   <= 1'b0;
      addr_q <= '0;
      line_q <= '0;
    end else if (start) begin
      we_q   <= 1'b1;
      addr_q <= addr;
      line_q <= line;
    end else if (we_q && u_rdy) begin
      we_q   <= 1'b0;
    end
  end

  assign wb_we   = we_q;
  assign wb_addr = we_q ? addr_q : '0;
  assign wb_line = we_q ? line_q : '0;

endmodule

// File: rtl/snoop_resp.sv
// snoop_resp: per-CPU snoop responder (lookup, forward, downgrade).
// SNOOP_WB_EN: when defined, MODIFIED hits write back via snoop_wb.
module snoop_resp
  import smp_pkg::*;
#(
  parameter int INDEX_W = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cpu_search,
  input  logic                      invalidate_from_other_cpu,
  input  logic [BOCI_W-1:0]         BOCI,
  output logic                      cpu_search_found,
  output logic [LINE_W-1:0]         send_other_proc_data,
  output logic                      snoop_done,
  output logic                      snoop_busy,
  output logic [INDEX_W-1:0]        snp_idx,
  input  logic [BOCI_W-INDEX_W-1:0] snp_tag_rd,
  input  logic [1:0]                snp_state_rd,
  input  logic [LINE_W-1:0]         snp_line_rd,
  output logic                      snp_state_we,
  output logic [1:0]                snp_state_wdata,
  output logic                      wb_we,
  output logic [DMEM_AW-1:0]        wb_addr,
  output logic [LINE_W-1:0]         wb_line,
  input  logic                      u_rdy
);

  snoop_state_t        state, state_d;
  logic [BOCI_W-1:0]   boci_q;
  logic                inv_q;
  block_state_t        new_q, new_d;
  logic                req;
  logic                hit;
  logic                wb_start;

  assign req = cpu_search | invalidate_from_other_cpu;
  assign hit = (snp_tag_rd == boci_q[BOCI_W-1:INDEX_W]) &&
               is_valid(snp_state_rd);

  // state register plus request capture in IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      boci_q <= '0;
      inv_q  <= 1'b0;
      new_q  <= INVALID;
    end else begin
      state  <= state_d;
      new_q  <= new_d;
      if (state == IDLE && req) begin
        boci_q <= BOCI;
        inv_q  <= invalidate_from_other_cpu;
      end
    end
  end

  // next state and per-state outputs
  always_comb begin
    state_d              = state;
    new_d                = new_q;
    cpu_search_found     = 1'b0;
    send_other_proc_data = '0;
    snoop_done           = 1'b0;
    snp_idx              = '0;
    snp_state_we         = 1'b0;
    snp_state_wdata      = INVALID;
    wb_start             = 1'b0;
    unique case (state)
      IDLE: begin
        if (req) state_d = LOOKUP;
      end
      LOOKUP: begin
        snp_idx = boci_q[INDEX_W-1:0];
        state_d = RESP;
      end
      RESP: begin
        snp_idx          = boci_q[INDEX_W-1:0];
        cpu_search_found = hit;
        if (hit) send_other_proc_data = snp_line_rd;
        if (!hit) begin
          snoop_done = 1'b1;
          state_d    = IDLE;
        end else if (snp_state_rd == SHARED) begin
          if (inv_q) begin
            new_d   = INVALID;
            state_d = UPDATE;
          end else begin
            snoop_done = 1'b1;
            state_d    = IDLE;
          end
        end else begin
          new_d = inv_q ? INVALID : SHARED;
`ifdef SNOOP_WB_EN
          wb_start = 1'b1;
          state_d  = WB;
`else
          state_d  = UPDATE;
`endif
        end
      end
`ifdef SNOOP_WB_EN
      WB: begin
        snp_idx = boci_q[INDEX_W-1:0];
        if (u_rdy) state_d = UPDATE;
      end
`endif
      UPDATE: begin
        snp_idx         = boci_q[INDEX_W-1:0];
        snp_state_we    = 1'b1;
        snp_state_wdata = new_q;
        snoop_done      = 1'b1;
        state_d         = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign snoop_busy = (state != IDLE);

  snoop_wb u_wb (
    .clk   (clk),
    .rst_n (rst_n),
    .start (wb_start),
    .addr  (boci_q[DMEM_AW-1:0]),
    .line  (snp_line_rd),
    .u_rdy (u_rdy),
    .wb_we (wb_we),
    .wb_addr(wb_addr),
    .wb_line(wb_line)
  );

endmodule
